// File: rtl/ifetch_bus_if.sv
// SRAM-like instruction bus between the fetch controller (master) and the
// instruction memory/cache (slave): one address phase, one data phase.
`timescale 1ns/1ps
interface ifetch_bus_if #(
  parameter int DATA_W = 32
);
  logic              inst_req;
  logic [DATA_W-1:0] inst_addr;
  logic              inst_addr_ok;
  logic              inst_data_ok;
  logic [DATA_W-1:0] inst_rdata;

  modport master (
    output inst_req,
    output inst_addr,
    input  inst_addr_ok,
    input  inst_data_ok,
    input  inst_rdata
  );

  modport slave (
    input  inst_req,
    input  inst_addr,
    output inst_addr_ok,
    output inst_data_ok,
    output inst_rdata
  );
endinterface

// File: rtl/ifetch_ctrl.sv
// Instruction fetch controller: issues one bus read per PC, holds the result
// for decode under stall, and drains/discards transactions abandoned by flush.
`timescale 1ns/1ps
module ifetch_ctrl #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] pc,
  input  logic              stall,
  input  logic              flush,
  ifetch_bus_if.master      bus,
  output logic [DATA_W-1:0] instr,
  output logic [DATA_W-1:0] instr_pc,
  output logic              i_data_ok,
  output logic              adel
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    REQ     = 3'd1,
    WAIT    = 3'd2,
    DISCARD = 3'd3,
    DONE    = 3'd4
  } state_t;

  state_t            state, state_nxt;
  logic [DATA_W-1:0] instr_r, instr_nxt;
  logic [DATA_W-1:0] pc_r, pc_nxt;
  logic              adel_r, adel_nxt;
  logic              misaligned;

  assign misaligned = (pc[1:0] != 2'b00);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      instr_r <= '0;
      pc_r    <= '0;
      adel_r  <= 1'b0;
    end else begin
      state   <= state_nxt;
      instr_r <= instr_nxt;
      pc_r    <= pc_nxt;
      adel_r  <= adel_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    instr_nxt = instr_r;
    pc_nxt    = pc_r;
    adel_nxt  = adel_r;
    case (state)
      IDLE: state_nxt = REQ;
      REQ: begin
        // A misaligned PC never reaches the bus; it is reported as a fetch fault.
        if (misaligned) begin
          if (!flush) begin
            state_nxt = DONE;
            instr_nxt = '0;
            pc_nxt    = pc;
            adel_nxt  = 1'b1;
          end
        end else if (bus.inst_addr_ok) begin
          if (flush) begin
            state_nxt = DISCARD;
          end else begin
            state_nxt = WAIT;
            pc_nxt    = pc;
            adel_nxt  = 1'b0;
          end
        end
      end
      WAIT: begin
        if (bus.inst_data_ok) begin
          if (flush) begin
            state_nxt = REQ;
          end else begin
            state_nxt = DONE;
            instr_nxt = bus.inst_rdata;
          end
        end else if (flush) begin
          state_nxt = DISCARD;
        end
      end
      // The accepted read must still complete before the next one may start.
      DISCARD: if (bus.inst_data_ok) state_nxt = REQ;
      DONE:    if (flush || !stall) state_nxt = REQ;
      default: state_nxt = IDLE;
    endcase
  end

  assign bus.inst_req  = (state == REQ) && !misaligned;
  assign bus.inst_addr = pc;
  assign instr         = instr_r;
  assign instr_pc      = pc_r;
  assign i_data_ok     = (state == DONE);
  assign adel          = (state == DONE) && adel_r;

endmodule

// File: tb/tb_ifetch_ctrl.sv
// Directed bench for ifetch_ctrl: inputs change 1ns after the rising edge,
// outputs are sampled on the falling edge.
`timescale 1ns/1ps
module tb_ifetch_ctrl;
  logic        clk;
  logic        reset;
  logic [31:0] pc;
  logic        stall;
  logic        flush;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        i_data_ok;
  logic        adel;
  int          checks;
  int          errors;

  ifetch_bus_if bus ();

  ifetch_ctrl dut (
    .clk       (clk),
    .reset     (reset),
    .pc        (pc),
    .stall     (stall),
    .flush     (flush),
    .bus       (bus),
    .instr     (instr),
    .instr_pc  (instr_pc),
    .i_data_ok (i_data_ok),
    .adel      (adel)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic idle_bus();
    bus.inst_addr_ok = 1'b0;
    bus.inst_data_ok = 1'b0;
    bus.inst_rdata   = 32'h0;
  endtask

  task automatic test_reset();
    reset = 1'b1; pc = 32'hBFC0_0000; stall = 1'b0; flush = 1'b0;
    idle_bus();
    next_cycle();
    next_cycle();
    sample();
    checks++; if (bus.inst_req !== 1'b0) begin errors++; $display("FAIL rst_req: got %b expected 0", bus.inst_req); end
    checks++; if (i_data_ok !== 1'b0) begin errors++; $display("FAIL rst_idok: got %b expected 0", i_data_ok); end
    checks++; if (instr !== 32'h0) begin errors++; $display("FAIL rst_instr: got %h expected 00000000", instr); end
    checks++; if (instr_pc !== 32'h0) begin errors++; $display("FAIL rst_pc: got %h expected 00000000", instr_pc); end
    checks++; if (adel !== 1'b0) begin errors++; $display("FAIL rst_adel: got %b expected 0", adel); end
    next_cycle();
    reset = 1'b0;
    sample();
    checks++; if (bus.inst_req !== 1'b0) begin errors++; $display("FAIL idle_req: got %b expected 0", bus.inst_req); end
    next_cycle();
    sample();
    checks++; if (bus.inst_req !== 1'b1) begin errors++; $display("FAIL first_req: got %b expected 1", bus.inst_req); end
    checks++; if (bus.inst_addr !== 32'hBFC0_0000) begin errors++; $display("FAIL first_addr: got %h expected bfc00000", bus.inst_addr); end
  endtask

  // Entered in REQ with pc=BFC00000, addr_ok low.
  task automatic test_basic_fetch();
    next_cycle();
    bus.inst_addr_ok = 1'b1;
    sample();
    checks++; if (bus.inst_req !== 1'b1) begin errors++; $display("FAIL bf_req: got %b expected 1", bus.inst_req); end
    next_cycle();
    bus.inst_addr_ok = 1'b0; bus.inst_data_ok = 1'b1; bus.inst_rdata = 32'h3C08_0001;
    sample();
    checks++; if (bus.inst_req !== 1'b0) begin errors++; $display("FAIL bf_wait_req: got %b expected 0", bus.inst_req); end
    checks++; if (i_data_ok !== 1'b0) begin errors++; $display("FAIL bf_wait_idok: got %b expected 0", i_data_ok); end
    next_cycle();
    idle_bus();
    sample();
    checks++; if (i_data_ok !== 1'b1) begin errors++; $display("FAIL bf_idok: got %b expected 1", i_data_ok); end
    checks++; if (instr !== 32'h3C08_0001) begin errors++; $display("FAIL bf_instr: got %h expected 3c080001", instr); end
    checks++; if (instr_pc !== 32'hBFC0_0000) begin errors++; $display("FAIL bf_pc: got %h expected bfc00000", instr_pc); end
    checks++; if (adel !== 1'b0) begin errors++; $display("FAIL bf_adel: got %b expected 0", adel); end
    next_cycle();
    pc = 32'hBFC0_0004;
    sample();
    checks++; if (bus.inst_req !== 1'b1) begin errors++; $display("FAIL bf_next_req: got %b expected 1", bus.inst_req); end
    checks++; if (i_data_ok !== 1'b0) begin errors++; $display("FAIL bf_next_idok: got %b expected 0", i_data_ok); end
    checks++; if (instr !== 32'h3C08_0001) begin errors++; $display("FAIL bf_hold_instr: got %h expected 3c080001", instr); end
  endtask

  task automatic test_stall_hold();
    next_cycle();
    bus.inst_addr_ok = 1'b1;
    next_cycle();
    bus.inst_addr_ok = 1'b0; bus.inst_data_ok = 1'b1; bus.inst_rdata = 32'h2409_0002;
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      next_cycle();
      idle_bus();
      sample();
      checks++; if (i_data_ok !== 1'b1) begin errors++; $display("FAIL st_idok[%0d]: got %b expected 1", i, i_data_ok); end
      checks++; if (instr !== 32'h2409_0002) begin errors++; $display("FAIL st_instr[%0d]: got %h expected 24090002", i, instr); end
      checks++; if (bus.inst_req !== 1'b0) begin errors++; $display("FAIL st_req[%0d]: got %b expected 0", i, bus.inst_req); end
    end
    next_cycle();
    stall = 1'b0;
    sample();
    checks++; if (i_data_ok !== 1'b1) begin errors++; $display("FAIL st_release_idok: got %b expected 1", i_data_ok); end
    checks++; if (instr_pc !== 32'hBFC0_0004) begin errors++; $display("FAIL st_pc: got %h expected bfc00004", instr_pc); end
    next_cycle();
    pc = 32'hBFC0_0008;
    sample();
    checks++; if (bus.inst_req !== 1'b1) begin errors++; $display("FAIL st_next_req: got %b expected 1", bus.inst_req); end
    checks++; if (i_data_ok !== 1'b0) begin errors++; $display("FAIL st_next_idok: got %b expected 0", i_data_ok); end
  endtask

  task automatic test_flush_wait();
    next_cycle();
    bus.inst_addr_ok = 1'b1;
    next_cycle();
    bus.inst_addr_ok = 1'b0; flush = 1'b1;
    next_cycle();
    flush = 1'b0; pc = 32'hBFC0_0100;
    sample();
    checks++; if (bus.inst_req !== 1'b0) begin errors++; $display("FAIL fw_drain_req: got %b expected 0", bus.inst_req); end
    next_cycle();
    bus.inst_data_ok = 1'b1; bus.inst_rdata = 32'hDEAD_BEEF;
    sample();
    checks++; if (bus.inst_req !== 1'b0) begin errors++; $display("FAIL fw_dok_req: got %b expected 0", bus.inst_req); end
    checks++; if (i_data_ok !== 1'b0) begin errors++; $display("FAIL fw_dok_idok: got %b expected 0", i_data_ok); end
    next_cycle();
    idle_bus();
    sample();
    checks++; if (bus.inst_req !== 1'b1) begin errors++; $display("FAIL fw_new_req: got %b expected 1", bus.inst_req); end
    checks++; if (bus.inst_addr !== 32'hBFC0_0100) begin errors++; $display("FAIL fw_new_addr: got %h expected bfc00100", bus.inst_addr); end
    checks++; if (instr !== 32'h2409_0002) begin errors++; $display("FAIL fw_instr: got %h expected 24090002", instr); end
    checks++; if (i_data_ok !== 1'b0) begin errors++; $display("FAIL fw_idok: got %b expected 0", i_data_ok); end
    bus.inst_addr_ok = 1'b1;
    next_cycle();
    bus.inst_addr_ok = 1'b0; bus.inst_data_ok = 1'b1; bus.inst_rdata = 32'h1111_1111;
    next_cycle();
    idle_bus();
    sample();
    checks++; if (instr !== 32'h1111_1111) begin errors++; $display("FAIL fw_refetch_instr: got %h expected 11111111", instr); end
    checks++; if (instr_pc !== 32'hBFC0_0100) begin errors++; $display("FAIL fw_refetch_pc: got %h expected bfc00100", instr_pc); end
    next_cycle();
    pc = 32'hBFC0_0104;
  endtask

  task automatic test_flush_data_ok();
    bus.inst_addr_ok = 1'b1;
    next_cycle();
    bus.inst_addr_ok = 1'b0; bus.inst_data_ok = 1'b1; bus.inst_rdata = 32'hCAFE_BABE;
    flush = 1'b1;
    sample();
    checks++; if (i_data_ok !== 1'b0) begin errors++; $display("FAIL fd_wait_idok: got %b expected 0", i_data_ok); end
    next_cycle();
    flush = 1'b0; idle_bus();
    sample();
    checks++; if (bus.inst_req !== 1'b1) begin errors++; $display("FAIL fd_req: got %b expected 1", bus.inst_req); end
    checks++; if (i_data_ok !== 1'b0) begin errors++; $display("FAIL fd_idok: got %b expected 0", i_data_ok); end
    checks++; if (instr !== 32'h1111_1111) begin errors++; $display("FAIL fd_instr: got %h expected 11111111", instr); end
  endtask

  task automatic test_misaligned();
    next_cycle();
    pc = 32'hBFC0_0002;
    sample();
    checks++; if (bus.inst_req !== 1'b0) begin errors++; $display("FAIL ma_req: got %b expected 0", bus.inst_req); end
    next_cycle();
    pc = 32'hBFC0_0200;
    sample();
    checks++; if (i_data_ok !== 1'b1) begin errors++; $display("FAIL ma_idok: got %b expected 1", i_data_ok); end
    checks++; if (adel !== 1'b1) begin errors++; $display("FAIL ma_adel: got %b expected 1", adel); end
    checks++; if (instr !== 32'h0) begin errors++; $display("FAIL ma_instr: got %h expected 00000000", instr); end
    checks++; if (instr_pc !== 32'hBFC0_0002) begin errors++; $display("FAIL ma_pc: got %h expected bfc00002", instr_pc); end
    next_cycle();
    sample();
    checks++; if (adel !== 1'b0) begin errors++; $display("FAIL ma_adel_clr: got %b expected 0", adel); end
    checks++; if (bus.inst_req !== 1'b1) begin errors++; $display("FAIL ma_next_req: got %b expected 1", bus.inst_req); end
  endtask

  task automatic test_reset_in_wait();
    bus.inst_addr_ok = 1'b1;
    next_cycle();
    bus.inst_addr_ok = 1'b0;
    #2;
    reset = 1'b1;
    #1;
    checks++; if (bus.inst_req !== 1'b0) begin errors++; $display("FAIL rw_req: got %b expected 0", bus.inst_req); end
    checks++; if (i_data_ok !== 1'b0) begin errors++; $display("FAIL rw_idok: got %b expected 0", i_data_ok); end
    checks++; if (instr !== 32'h0) begin errors++; $display("FAIL rw_instr: got %h expected 00000000", instr); end
    checks++; if (instr_pc !== 32'h0) begin errors++; $display("FAIL rw_pc: got %h expected 00000000", instr_pc); end
    next_cycle();
    reset = 1'b0; bus.inst_data_ok = 1'b1; bus.inst_rdata = 32'hBAAD_F00D;
    sample();
    checks++; if (i_data_ok !== 1'b0) begin errors++; $display("FAIL rw_idle_idok: got %b expected 0", i_data_ok); end
    checks++; if (bus.inst_req !== 1'b0) begin errors++; $display("FAIL rw_idle_req: got %b expected 0", bus.inst_req); end
    next_cycle();
    sample();
    checks++; if (bus.inst_req !== 1'b1) begin errors++; $display("FAIL rw_req_again: got %b expected 1", bus.inst_req); end
    checks++; if (i_data_ok !== 1'b0) begin errors++; $display("FAIL rw_late_dok: got %b expected 0", i_data_ok); end
    next_cycle();
    bus.inst_data_ok = 1'b0; bus.inst_addr_ok = 1'b1;
    next_cycle();
    bus.inst_addr_ok = 1'b0; bus.inst_data_ok = 1'b1; bus.inst_rdata = 32'h8FA4_0000;
    next_cycle();
    idle_bus();
    sample();
    checks++; if (i_data_ok !== 1'b1) begin errors++; $display("FAIL rw_resume_idok: got %b expected 1", i_data_ok); end
    checks++; if (instr !== 32'h8FA4_0000) begin errors++; $display("FAIL rw_resume_instr: got %h expected 8fa40000", instr); end
    checks++; if (instr_pc !== 32'hBFC0_0200) begin errors++; $display("FAIL rw_resume_pc: got %h expected bfc00200", instr_pc); end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_basic_fetch();
    test_stall_hold();
    test_flush_wait();
    test_flush_data_ok();
    test_misaligned();
    test_reset_in_wait();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ifetch_ctrl.md
IFETCH_CTRL -- requirements
Module: ifetch_ctrl

Interface
REQ-001 Clock and reset SHALL be one clock and one asynchronous, active-high reset: clk input 1, reset input 1.
REQ-002 Ports SHALL be (name, direction, width, meaning):
- clk  in  1  pipeline clock
- reset  in  1  async active-high reset
- pc  in  32  fetch PC from F register
- stall  in  1  decode stalled; hold delivered instruction
- flush  in  1  redirect (exception/branch); abandon current fetch
- inst_req  out  1  SRAM-like bus request
- inst_addr  out  32  bus address
- inst_addr_ok  in  1  bus accepted address
- inst_data_ok  in  1  bus read data valid
- inst_rdata  in  32  bus read data
- instr  out  32  fetched instruction to F/D path
- instr_pc  out  32  PC of instr
- i_data_ok  out  1  instr/instr_pc valid; drives hazard stallF
- adel  out  1  address-error-on-fetch flag, valid with i_data_ok

Function
REQ-003 FSM states SHALL be IDLE, REQ, WAIT, DISCARD, DONE; 3-bit state register.
REQ-004 IDLE SHALL go to REQ unconditionally next cycle.
REQ-005 REQ SHALL drive inst_req=1, inst_addr=pc combinationally, except when pc[1:0]!=0.
REQ-006 REQ with pc[1:0]!=0 and flush=0 SHALL keep inst_req=0, go to DONE with instr_r=0, pc_r=pc, adel_r=1.
REQ-007 REQ, addr_ok=1, flush=0 SHALL latch pc_r=pc, adel_r=0, go to WAIT.
REQ-008 REQ, addr_ok=1, flush=1 SHALL go to DISCARD (accepted transaction must be drained).
REQ-009 REQ, addr_ok=0 SHALL stay in REQ, re-presenting current pc (flush ignored).
REQ-010 WAIT SHALL drive inst_req=0; data_ok=1, flush=0 → latch instr_r=inst_rdata, go to DONE.
REQ-011 WAIT, data_ok=1, flush=1 SHALL drop data, go to REQ.
REQ-012 WAIT, data_ok=0, flush=1 SHALL go to DISCARD; data_ok=0, flush=0 SHALL stay.
REQ-013 DISCARD SHALL drive inst_req=0, ignore flush, go to REQ on data_ok=1 without updating instr_r.
REQ-014 DONE SHALL drive i_data_ok=1, instr=instr_r, instr_pc=pc_r, adel=adel_r; inst_req=0.
REQ-015 DONE: flush=1 → REQ; flush=0, stall=0 → REQ (consumed); flush=0, stall=1 → stay, outputs held.
REQ-016 Outside DONE, i_data_ok and adel SHALL be 0; instr and instr_pc SHALL hold last registered values.
REQ-017 At most one bus transaction SHALL be outstanding; inst_req SHALL never be 1 outside REQ.
REQ-018 Minimum latency SHALL be: addr_ok in cycle t, data_ok in t+1 → i_data_ok=1 in t+2.
REQ-019 inst_rdata SHALL be sampled only in cycles where inst_data_ok=1 in WAIT.

Reset
REQ-020 Reset asserted SHALL force state=IDLE, instr_r=0, pc_r=0, adel_r=0 immediately (asynchronous), so inst_req=0 and i_data_ok=0.
REQ-021 Reset mid-transaction SHALL abandon it; any data_ok arriving in IDLE/REQ afterward SHALL be ignored (bus reset in same domain).
REQ-022 First request after reset release SHALL occur in the second clock edge's cycle (IDLE→REQ).

Verification
REQ-023 Bench SHALL cover:
- Basic fetch: pc=0xBFC00000, addr_ok same cycle, data_ok next cycle, rdata=0x3C080001 → i_data_ok=1 two cycles after addr_ok, instr=0x3C080001, instr_pc=0xBFC00000.
- Stall hold: DONE with stall=1 for 3 cycles → i_data_ok, instr constant, inst_req=0; stall=0 → REQ next cycle.
- Flush in WAIT: flush during WAIT, data_ok two cycles later with rdata=0xDEADBEEF → never delivered; new request issued for new pc cycle after data_ok.
- Flush coincident with data_ok in WAIT → data dropped, REQ next cycle, i_data_ok stays 0.
- Misaligned pc=0xBFC00002 → no inst_req, next cycle i_data_ok=1, adel=1, instr=0.
- Reset asserted in WAIT → state IDLE immediately, outputs 0; late data_ok ignored; normal fetch resumes.
